// File: rtl/set_sequencer.sv
// set_sequencer: drives N control lines through queued timed steps, optionally restoring the pre-step value.
module set_sequencer #(
  parameter int N = 1,
  parameter int PW = 16,
  parameter int DEPTH = 4,
  parameter logic [N-1:0] INIT = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [N-1:0]             cmd_state,
  input  logic [PW-1:0]            cmd_period,
  input  logic                     cmd_restore,
  input  logic                     abort,
  output logic [N-1:0]             signals,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = N + PW + 1;
  typedef enum logic {IDLE, HOLD} state_t;
  state_t r_state, w_next;
  logic [CW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0] r_level;
  logic [N-1:0] r_saved;
  logic [PW-1:0] r_cnt;
  logic r_restore;
  logic w_push, w_pop, w_end;
  logic [N-1:0] w_hs;
  logic [PW-1:0] w_hp;
  logic w_hr;
  assign cmd_ready = (r_level != (AW+1)'(DEPTH)) && !abort;
  assign w_push = cmd_valid && cmd_ready;
  assign w_pop = (r_state == IDLE) && (r_level != '0) && !abort;
  assign w_end = (r_state == HOLD) && (r_cnt == '0) && !abort;
  assign {w_hs, w_hp, w_hr} = r_mem[r_rd];
  assign busy = (r_state == HOLD) || (r_level != '0);
  assign level = r_level;
  always_comb begin
    w_next = r_state;
    w_next = abort ? IDLE : w_pop ? HOLD : w_end ? IDLE : r_state;
  end
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wr] <= {cmd_state, cmd_period, cmd_restore};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_wr      <= '0;
      r_rd      <= '0;
      r_level   <= '0;
      signals   <= INIT;
      r_saved   <= INIT;
      r_cnt     <= '0;
      r_restore <= 1'b0;
      done      <= 1'b0;
    end else begin
      r_state <= w_next;
      done    <= w_end;
      if (abort) begin
        r_wr    <= '0;
        r_rd    <= '0;
        r_level <= '0;
        if (r_state == HOLD && r_restore) signals <= r_saved;
      end else begin
        r_wr    <= r_wr + AW'(w_push);
        r_rd    <= r_rd + AW'(w_pop);
        r_level <= r_level + (AW+1)'(w_push) - (AW+1)'(w_pop);
        if (w_pop) begin
          r_saved   <= signals;
          signals   <= w_hs;
          r_cnt     <= (w_hp == '0) ? '0 : w_hp - PW'(1);
          r_restore <= w_hr;
        end else if (r_state == HOLD) begin
          if (r_cnt != '0) r_cnt <= r_cnt - PW'(1);
          else if (r_restore) signals <= r_saved;
        end
      end
    end
  end
endmodule

// File: tb/tb_set_sequencer.sv
// tb_set_sequencer: directed and random steps checked every cycle against a queue-based step model.
module tb_set_sequencer;
  localparam int N = 4;
  localparam int PW = 16;
  localparam int DEPTH = 4;
  localparam logic [N-1:0] INIT = 4'h0;
  logic clk = 1'b0, rst_n = 1'b1, cmd_valid = 1'b0, cmd_restore = 1'b0, abort = 1'b0;
  logic [N-1:0] cmd_state = '0;
  logic [PW-1:0] cmd_period = '0;
  logic cmd_ready, busy, done;
  logic [N-1:0] signals;
  logic [$clog2(DEPTH):0] level;
  set_sequencer #(.N(N), .PW(PW), .DEPTH(DEPTH), .INIT(INIT)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_state(cmd_state), .cmd_period(cmd_period), .cmd_restore(cmd_restore),
    .abort(abort), .signals(signals), .busy(busy), .done(done), .level(level)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [N-1:0] s;
    int unsigned  p;
    logic         r;
  } cmd_t;
  cmd_t q[$];
  logic [N-1:0] m_sig, m_saved, watch, pre;
  logic m_rst, m_done;
  int unsigned m_left;
  int errors = 0, checks = 0, dones = 0, seen = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    q.delete();
    m_sig = INIT;
    m_saved = INIT;
    m_rst = 1'b0;
    m_done = 1'b0;
    m_left = 0;
  endtask
  // One rising edge of the reference: a step shows its state for max(period,1) cycles.
  task automatic model_edge(input logic v, input logic [N-1:0] s, input int unsigned p,
                            input logic r, input logic a);
    cmd_t c;
    logic rdy;
    rdy = (q.size() < DEPTH) && !a;
    m_done = 1'b0;
    if (a) begin
      q.delete();
      if (m_left > 0 && m_rst) m_sig = m_saved;
      m_left = 0;
    end else begin
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          if (m_rst) m_sig = m_saved;
          m_done = 1'b1;
        end
      end else if (q.size() > 0) begin
        c = q.pop_front();
        m_saved = m_sig;
        m_sig = c.s;
        m_rst = c.r;
        m_left = (c.p == 0) ? 1 : c.p;
      end
      if (v && rdy) begin
        c.s = s;
        c.p = p;
        c.r = r;
        q.push_back(c);
      end
    end
  endtask
  task automatic step(input logic v, input logic [N-1:0] s, input int unsigned p,
                      input logic r, input logic a);
    cmd_valid = v;
    cmd_state = s;
    cmd_period = PW'(p);
    cmd_restore = r;
    abort = a;
    #1;
    chk("cmd_ready", 32'(cmd_ready), 32'((q.size() < DEPTH) && !a));
    @(posedge clk);
    model_edge(v, s, p, r, a);
    #1;
    chk("signals", 32'(signals), 32'(m_sig));
    chk("level", 32'(level), 32'(q.size()));
    chk("busy", 32'(busy), 32'((m_left > 0) || (q.size() > 0)));
    chk("done", 32'(done), 32'(m_done));
    if (done === 1'b1) dones++;
    if (signals === watch) seen++;
    cmd_valid = 1'b0;
    abort = 1'b0;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 0, 1'b0, 1'b0);
  endtask
  task automatic push_held(input logic [N-1:0] s, input int unsigned p, input logic r);
    logic acc;
    for (int i = 0; i < 300; i++) begin
      acc = q.size() < DEPTH;
      step(1'b1, s, p, r, 1'b0);
      if (acc) return;
    end
    chk("push_timeout", 32'd1, 32'd0);
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_signals", 32'(signals), 32'(INIT));
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    #2;
    rst_n = 1'b1;
  endtask
  initial begin
    watch = 4'hF;
    @(posedge clk);
    #3;
    do_reset();
    idle(2);
    watch = 4'hA; seen = 0; dones = 0;
    push_held(4'hA, 3, 1'b1);
    idle(8);
    chk("t2_cycles", 32'(seen), 32'd3);
    chk("t2_done", 32'(dones), 32'd1);
    chk("t2_final", 32'(signals), 32'h0);
    watch = 4'h1; seen = 0; dones = 0;
    step(1'b1, 4'h1, 2, 1'b0, 1'b0);
    step(1'b1, 4'h0, 0, 1'b0, 1'b0);
    idle(8);
    chk("t3_high", 32'(seen), 32'd3);
    chk("t3_done", 32'(dones), 32'd2);
    push_held(4'h5, 20, 1'b1);
    push_held(4'h6, 2, 1'b0);
    push_held(4'h7, 2, 1'b0);
    push_held(4'h8, 2, 1'b0);
    push_held(4'h9, 2, 1'b0);
    chk("t4_level", 32'(level), 32'd4);
    dones = 0;
    push_held(4'hB, 1, 1'b0);
    idle(40);
    chk("t4_done", 32'(dones), 32'd6);
    chk("t4_final", 32'(signals), 32'hB);
    pre = m_sig;
    push_held(4'hF, 10, 1'b1);
    push_held(4'h1, 3, 1'b0);
    push_held(4'h2, 3, 1'b0);
    idle(2);
    dones = 0;
    step(1'b1, 4'h7, 3, 1'b0, 1'b1);
    chk("t5_sig", 32'(signals), 32'(pre));
    chk("t5_level", 32'(level), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    idle(5);
    chk("t5_done", 32'(dones), 32'd0);
    watch = 4'h3; seen = 0;
    push_held(4'h3, 0, 1'b1);
    idle(4);
    chk("t6_p0", 32'(seen), 32'd1);
    watch = 4'h9; seen = 0; dones = 0;
    push_held(4'h9, 16'hFFFF, 1'b1);
    idle(65540);
    chk("t6_max", 32'(seen), 32'd65535);
    chk("t6_done", 32'(dones), 32'd1);
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 1)), N'($urandom), $urandom_range(0, 4),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 19) == 0));
    step(1'b0, '0, 0, 1'b0, 1'b1);
    idle(2);
    push_held(4'hC, 8, 1'b1);
    idle(3);
    @(posedge clk);
    #3;
    do_reset();
    dones = 0;
    idle(12);
    chk("t7_done", 32'(dones), 32'd0);
    chk("t7_sig", 32'(signals), 32'(INIT));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
